// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers the CPU MEM stage after a fixed
// number of wait cycles. Accesses are serialized and faults are flagged in RESP.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        stall_o,
  output logic        err_o
);
  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT    = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic [31:0]     addr_q;
  logic [31:0]     data_q;
  logic            wr_q;
  logic            conflict_q;
  logic [31:0]     mem [DEPTH_WORDS];
  logic            req;
  logic            fault;
  logic            finish;
  logic [AW-1:0]   idx;

  assign req    = MemRead_i | MemWrite_i;
  assign idx    = addr_q[AW+1:2];
  assign fault  = (addr_q[1:0] != 2'b00) || (addr_q >= LIMIT);
  assign finish = (state == BUSY) && (cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture stage: request latched in IDLE, countdown in BUSY, read result on exit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      conflict_q <= 1'b0;
      data_o     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        addr_q     <= addr_i;
        data_q     <= data_i;
        wr_q       <= MemWrite_i;
        conflict_q <= MemRead_i & MemWrite_i;
        cnt        <= CNT_LOAD;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (finish && !wr_q)
        data_o <= fault ? 32'd0 : mem[idx];
    end
  end

  // Storage is deliberately outside the reset domain; reset only blocks the commit
  always_ff @(posedge clk_i) begin
    if (finish && wr_q && !fault && !rst_i)
      mem[idx] <= data_q;
  end

  assign stall_o = ((state == IDLE) && req) || (state == BUSY);
  assign valid_o = (state == RESP) && !wr_q;
  assign err_o   = (state == RESP) && (fault || conflict_q);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH_WORDS=256, LATENCY=3).
module tb_data_mem_responder;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        stall_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .stall_o    (stall_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge, idle again.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_v, input logic exp_e, input logic [31:0] exp_d);
    int n;
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = a;
    data_i     = d;
    #1;
    n = 0;
    while (stall_o && n < 40) begin
      n++;
      @(negedge clk_i);
    end
    check({tag, "_stall_cycles"}, 32'(n), 32'd4);
    check({tag, "_valid"}, {31'd0, valid_o}, {31'd0, exp_v});
    check({tag, "_err"}, {31'd0, err_o}, {31'd0, exp_e});
    check({tag, "_data"}, data_o, exp_d);
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    @(negedge clk_i);
    check({tag, "_valid_drop"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_err_drop"}, {31'd0, err_o}, 32'd0);
    check({tag, "_data_hold"}, data_o, exp_d);
  endtask

  initial begin
    rst_i      = 1'b1;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    addr_i     = '0;
    data_i     = '0;
    repeat (2) @(negedge clk_i);
    check("rst_data", data_o, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_stall_idle", {31'd0, stall_o}, 32'd0);
    MemRead_i = 1'b1;
    #1;
    check("rst_stall_req", {31'd0, stall_o}, 32'd1);
    MemRead_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;

    access("wr_10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    access("rd_10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
    access("wr_0", 1'b0, 1'b1, 32'h0, 32'h11111111, 1'b0, 1'b0, 32'hDEADBEEF);
    access("wr_4", 1'b0, 1'b1, 32'h4, 32'h22222222, 1'b0, 1'b0, 32'hDEADBEEF);
    access("rd_4", 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h22222222);
    access("rd_0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h11111111);
    access("rd_6_misaligned", 1'b1, 1'b0, 32'h6, 32'h0, 1'b1, 1'b1, 32'h0);
    access("wr_400_range", 1'b0, 1'b1, 32'h400, 32'hAAAAAAAA, 1'b0, 1'b1, 32'h0);
    access("wr_1_misaligned", 1'b0, 1'b1, 32'h1, 32'h99999999, 1'b0, 1'b1, 32'h0);
    access("rd_0_after_faults", 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h11111111);
    access("wr_3fc_last", 1'b0, 1'b1, 32'h3FC, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h11111111);
    access("rd_3fc_last", 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b1, 1'b0, 32'hA5A5A5A5);
    access("both_8", 1'b1, 1'b1, 32'h8, 32'h55AA55AA, 1'b0, 1'b1, 32'hA5A5A5A5);
    access("rd_8", 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h55AA55AA);
    access("wr_20_pre", 1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'h55AA55AA);

    // Reset during the second BUSY cycle of a write must abort the commit
    MemWrite_i = 1'b1;
    addr_i     = 32'h20;
    data_i     = 32'hCAFEF00D;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    check("abort_stall_before", {31'd0, stall_o}, 32'd1);
    rst_i      = 1'b1;
    MemWrite_i = 1'b0;
    #1;
    check("abort_stall_drop", {31'd0, stall_o}, 32'd0);
    check("abort_data_clear", data_o, 32'd0);
    check("abort_err", {31'd0, err_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    access("rd_20_after_abort", 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256; the number of 32-bit storage words, a power of two between 4 and 4096 inclusive.
REQ-002 Parameter LATENCY, default 3; the number of wait cycles per access, from 1 to 15 inclusive.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk_i and rst_i.
REQ-004 clk_i  input  1  rising-edge clock for all state.
REQ-005 rst_i  input  1  asynchronous reset, active high.
REQ-006 MemRead_i  input  1  read request from the CPU MEM stage, held stable while stall_o=1.
REQ-007 MemWrite_i  input  1  write request from the CPU MEM stage, held stable while stall_o=1.
REQ-008 addr_i  input  32  byte address of the access.
REQ-009 data_i  input  32  write data.
REQ-010 data_o  output  32  registered read data.
REQ-011 valid_o  output  1  one-cycle pulse marking a completed read.
REQ-012 stall_o  output  1  pipeline freeze request to the CPU.
REQ-013 err_o  output  1  one-cycle pulse marking a faulted access.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-015 In IDLE with MemRead_i|MemWrite_i=1: capture addr_i, data_i and op at the clock edge, load cnt=LATENCY-1, go to BUSY.
REQ-016 When both request bits are 1, the access SHALL be treated as a write and err_o SHALL pulse in RESP; the write still commits if the address is legal.
REQ-017 In BUSY: if cnt!=0, decrement cnt; if cnt==0, go to RESP.
REQ-018 RESP SHALL always go to IDLE on the next edge; requests sampled in RESP are ignored because they are the old request.
REQ-019 stall_o = (IDLE & (MemRead_i|MemWrite_i)) | BUSY, combinational, and 0 in RESP.
REQ-020 As a consequence, stall_o SHALL be high for exactly LATENCY+1 consecutive cycles per access.
REQ-021 Write commit: on the edge leaving BUSY, mem[idx] <= captured data.
REQ-022 Read: on the edge leaving BUSY, data_o <= mem[idx], and valid_o=1 during RESP only.
REQ-023 idx SHALL equal captured addr[log2(DEPTH_WORDS)+1:2].
REQ-024 Fault: captured addr[1:0]!=0, or addr >= 4*DEPTH_WORDS, SHALL cause err_o=1 in RESP and suppress the write.
REQ-025 On a faulted read, data_o SHALL be loaded with 0 and valid_o still pulses.
REQ-026 data_o SHALL hold its value between reads; writes do not change it.
REQ-027 A read of a word written by the immediately preceding access SHALL return the new value, with no bypass hazard, because the accesses are serialized.
REQ-028 Back-to-back requests: after RESP, the next request is recognised in IDLE, giving a minimum of LATENCY+2 cycles per access.
REQ-029 Request inputs are don't-care in BUSY; the captured values are used.

Reset
REQ-030 While rst_i=1: state=IDLE, cnt=0, data_o=0, valid_o=0, err_o=0, and captured registers are 0.
REQ-031 stall_o during reset SHALL follow REQ-019 with state IDLE.
REQ-032 The storage array SHALL NOT be cleared by reset.
REQ-033 Reset asserted in BUSY or RESP SHALL abort the access: no write commit, and data_o returns to 0.
REQ-034 After rst_i deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-035 LATENCY=3: write 0xDEADBEEF to 0x10, then read 0x10 -> stall_o high for 4 cycles on each access; on the read, data_o=0xDEADBEEF with valid_o high for 1 cycle.
REQ-036 Write 0x11111111 to 0x0, then read 0x4 after 0x4 was written with 0x22222222 -> data_o=0x22222222; then read 0x0 -> data_o=0x11111111, confirming no aliasing.
REQ-037 Read 0x6 (misaligned) -> err_o pulse, data_o=0, valid_o pulse.
REQ-038 Write to 0x400 with DEPTH_WORDS=256 -> err_o pulse and no word modified; a subsequent read of 0x0 returns its prior value.
REQ-039 Assert rst_i in the 2nd BUSY cycle of a write of 0xCAFEF00D to 0x20 -> after reset, a read of 0x20 returns the pre-write contents, and stall_o drops within the reset cycle.
REQ-040 Assert MemRead_i and MemWrite_i together with 0x55AA55AA to 0x8 -> err_o pulse; a following read of 0x8 returns 0x55AA55AA.
